// File: rtl/x2050_psw_pkg.sv
// Shared definitions for the 2050 interrupt priority arbiter and PSW-swap
// sequencer: state encoding, class one-hot indices, low-storage slot map
// and the priority rule used to pick a winner.
package x2050_psw_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ST0  = 3'd1,
    S_ST1  = 3'd2,
    S_LD0  = 3'd3,
    S_LD1  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // One-hot class positions on o_sel / o_grant: {mck,pgm,svc,ext,io}.
  localparam int CL_MCK  = 4;
  localparam int CL_PGM  = 3;
  localparam int CL_SVC  = 2;
  localparam int CL_EXT  = 1;
  localparam int CL_IO   = 0;
  localparam int N_CLASS = 5;

  // Priority order follows the one-hot index: mck highest, io lowest.
  localparam int PRI_HIGH = CL_MCK;
  localparam int PRI_LOW  = CL_IO;

  // Old-PSW slots; the new-PSW slot of every class sits 0x40 above.
  localparam logic [7:0] OLD_EXT    = 8'h18;
  localparam logic [7:0] OLD_SVC    = 8'h20;
  localparam logic [7:0] OLD_PGM    = 8'h28;
  localparam logic [7:0] OLD_MCK    = 8'h30;
  localparam logic [7:0] OLD_IO     = 8'h38;
  localparam logic [7:0] NEW_OFFSET = 8'h40;

  function automatic logic [7:0] old_slot(input logic [N_CLASS-1:0] sel);
    logic [7:0] a;
    a = 8'h00;
    if (sel[CL_MCK])      a = OLD_MCK;
    else if (sel[CL_PGM]) a = OLD_PGM;
    else if (sel[CL_SVC]) a = OLD_SVC;
    else if (sel[CL_EXT]) a = OLD_EXT;
    else if (sel[CL_IO])  a = OLD_IO;
    return a;
  endfunction

  // Scan from lowest to highest priority so the highest enabled class wins.
  function automatic logic [N_CLASS-1:0] pri_pick(input logic [N_CLASS-1:0] en);
    logic [N_CLASS-1:0] r;
    r = '0;
    for (int i = PRI_LOW; i <= PRI_HIGH; i++) begin
      if (en[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/x2050_int_pri.sv
// Combinational masking of pending interrupt classes against the system
// mask and the M bit, followed by the class priority encode and the
// lowest-numbered I/O channel pick.
module x2050_int_pri
  import x2050_psw_pkg::*;
(
  input  logic               i_mck_req,
  input  logic               i_pgm_req,
  input  logic               i_svc_req,
  input  logic               i_ext_req,
  input  logic [5:0]         i_io_req,
  input  logic [7:0]         i_sysmask,
  input  logic               i_m_bit,
  output logic [N_CLASS-1:0] o_sel,
  output logic [2:0]         o_io_chan,
  output logic               o_any
);

  logic [5:0]         w_io_en;
  logic [N_CLASS-1:0] w_en;
  logic [2:0]         w_chan;

  // Mask each class; PSW bit n lives at i_sysmask[7-n], ext uses PSW bit 7
  always_comb begin
    w_io_en = '0;
    for (int n = 0; n < 6; n++) begin
      w_io_en[n] = i_io_req[n] & i_sysmask[7-n];
    end
    w_en         = '0;
    w_en[CL_MCK] = i_mck_req & i_m_bit;
    w_en[CL_PGM] = i_pgm_req;
    w_en[CL_SVC] = i_svc_req;
    w_en[CL_EXT] = i_ext_req & i_sysmask[0];
    w_en[CL_IO]  = |w_io_en;
  end

  // Lowest enabled channel number wins among the I/O requests
  always_comb begin
    w_chan = 3'd0;
    for (int n = 5; n >= 0; n--) begin
      if (w_io_en[n]) w_chan = 3'(n);
    end
  end

  assign o_sel     = pri_pick(w_en);
  assign o_io_chan = o_sel[CL_IO] ? w_chan : 3'd0;
  assign o_any     = |w_en;

endmodule

// File: rtl/x2050_psw_swap.sv
// Interrupt priority arbiter and PSW-swap sequencer for the 2050 model.
// Stores the old PSW (with interrupt code and ILC folded in) to the
// winning class's old slot, fetches the new PSW from its new slot and
// presents it with a one-cycle load/grant pulse.
// Optional build macro X2050_NEWPSW_CHECK_EN adds o_spec_err, flagging a
// fetched new PSW whose instruction address is odd.
module x2050_psw_swap
  import x2050_psw_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ros_advance,
  input  logic              i_mck_req,
  input  logic              i_pgm_req,
  input  logic              i_svc_req,
  input  logic              i_ext_req,
  input  logic [5:0]        i_io_req,
  input  logic [7:0]        i_sysmask,
  input  logic [3:0]        i_amwp,
  input  logic [63:0]       i_psw,
  input  logic [15:0]       i_int_code,
  input  logic [1:0]        i_ilc,
  output logic [4:0]        o_sel,
  output logic [2:0]        o_io_chan,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic [63:0]       o_new_psw,
  output logic              o_psw_load,
  output logic [4:0]        o_grant,
`ifdef X2050_NEWPSW_CHECK_EN
  output logic              o_spec_err,
`endif
  output logic              o_busy,
  output logic              o_wait
);

  logic [4:0]  w_sel;
  logic [2:0]  w_io_chan;
  logic        w_any;
  state_t      r_state;
  state_t      w_next;
  logic [7:0]  w_slot;
  logic [4:0]  r_sel;
  logic [2:0]  r_io_chan;
  logic [15:0] r_int_code;
  logic [1:0]  r_ilc;
  logic [15:0] r_psw_hi;
  logic [29:0] r_psw_lo;
  logic        r_mem_req;
  logic [63:0] r_new_psw;
  logic        r_psw_load;
  logic [4:0]  r_grant;
  logic        r_spec_err;
  logic        w_unused;

  x2050_int_pri u_pri (
    .i_mck_req (i_mck_req),
    .i_pgm_req (i_pgm_req),
    .i_svc_req (i_svc_req),
    .i_ext_req (i_ext_req),
    .i_io_req  (i_io_req),
    .i_sysmask (i_sysmask),
    .i_m_bit   (i_amwp[2]),
    .o_sel     (w_sel),
    .o_io_chan (w_io_chan),
    .o_any     (w_any)
  );

  // Successor of each storage state once its access and dead cycle are done
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_ST0:   w_next = S_ST1;
      S_ST1:   w_next = S_LD0;
      S_LD0:   w_next = S_LD1;
      S_LD1:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Low-storage byte address touched by the current storage state
  always_comb begin
    w_slot = 8'h00;
    case (r_state)
      S_ST0:   w_slot = old_slot(r_sel);
      S_ST1:   w_slot = old_slot(r_sel) + 8'h04;
      S_LD0:   w_slot = old_slot(r_sel) + NEW_OFFSET;
      S_LD1:   w_slot = old_slot(r_sel) + NEW_OFFSET + 8'h04;
      default: w_slot = 8'h00;
    endcase
  end

  // Swap sequencer: each storage state runs a request phase (r_mem_req
  // high until ack) and then one dead cycle before moving on
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_io_chan  <= '0;
      r_int_code <= '0;
      r_ilc      <= '0;
      r_psw_hi   <= '0;
      r_psw_lo   <= '0;
      r_mem_req  <= 1'b0;
      r_new_psw  <= '0;
      r_psw_load <= 1'b0;
      r_grant    <= '0;
      r_spec_err <= 1'b0;
    end else begin
      r_psw_load <= 1'b0;
      r_grant    <= '0;
      r_spec_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_ros_advance && w_any) begin
            r_state    <= S_ST0;
            r_mem_req  <= 1'b1;
            r_sel      <= w_sel;
            r_io_chan  <= w_io_chan;
            r_int_code <= i_int_code;
            r_ilc      <= i_ilc;
            r_psw_hi   <= i_psw[63:48];
            r_psw_lo   <= i_psw[29:0];
          end
        end
        S_ST0, S_ST1, S_LD0, S_LD1: begin
          if (r_mem_req) begin
            if (i_mem_ack) begin
              r_mem_req <= 1'b0;
              if (r_state == S_LD0) r_new_psw[63:32] <= i_mem_rdata;
              if (r_state == S_LD1) r_new_psw[31:0]  <= i_mem_rdata;
            end
          end else begin
            r_state <= w_next;
            if (r_state == S_LD1) begin
              r_psw_load <= 1'b1;
              r_grant    <= r_sel;
              r_spec_err <= r_new_psw[0];
            end else begin
              r_mem_req <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sel       = (r_state == S_IDLE) ? w_sel : r_sel;
  assign o_io_chan   = (r_state == S_IDLE) ? w_io_chan : r_io_chan;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = (r_state == S_ST0) || (r_state == S_ST1);
  assign o_mem_addr  = ADDR_W'(w_slot);
  assign o_mem_wdata = (r_state == S_ST0) ? {r_psw_hi, r_int_code} :
                       (r_state == S_ST1) ? {r_ilc, r_psw_lo} : 32'h0;
  assign o_new_psw   = r_new_psw;
  assign o_psw_load  = r_psw_load;
  assign o_grant     = r_grant;
  assign o_busy      = (r_state != S_IDLE);
  assign o_wait      = i_amwp[1] & (r_state == S_IDLE) & ~w_any;
`ifdef X2050_NEWPSW_CHECK_EN
  assign o_spec_err  = r_spec_err;
  assign w_unused    = ^{i_amwp[3], i_amwp[0], i_psw[47:30]};
`else
  assign w_unused    = ^{i_amwp[3], i_amwp[0], i_psw[47:30], r_spec_err};
`endif

endmodule

// File: tb/tb_x2050_psw_swap.sv
// Self-checking bench for x2050_psw_swap: directed scenarios plus a
// randomized loop compared against a rule-level reference model and a
// latency-programmable storage responder.
module tb_x2050_psw_swap;

  localparam int ADDR_W = 24;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_ros_advance = 1'b0;
  logic              i_mck_req = 1'b0, i_pgm_req = 1'b0, i_svc_req = 1'b0, i_ext_req = 1'b0;
  logic [5:0]        i_io_req = '0;
  logic [7:0]        i_sysmask = '0;
  logic [3:0]        i_amwp = '0;
  logic [63:0]       i_psw = '0;
  logic [15:0]       i_int_code = '0;
  logic [1:0]        i_ilc = '0;
  logic [4:0]        o_sel;
  logic [2:0]        o_io_chan;
  logic              o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_ack = 1'b0;
  logic [31:0]       i_mem_rdata = '0;
  logic [63:0]       o_new_psw;
  logic              o_psw_load;
  logic [4:0]        o_grant;
  logic              o_busy, o_wait;
`ifdef X2050_NEWPSW_CHECK_EN
  logic              o_spec_err;
`endif

  x2050_psw_swap #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ros_advance(i_ros_advance),
    .i_mck_req(i_mck_req), .i_pgm_req(i_pgm_req), .i_svc_req(i_svc_req),
    .i_ext_req(i_ext_req), .i_io_req(i_io_req), .i_sysmask(i_sysmask),
    .i_amwp(i_amwp), .i_psw(i_psw), .i_int_code(i_int_code), .i_ilc(i_ilc),
    .o_sel(o_sel), .o_io_chan(o_io_chan), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_new_psw(o_new_psw),
    .o_psw_load(o_psw_load), .o_grant(o_grant),
`ifdef X2050_NEWPSW_CHECK_EN
    .o_spec_err(o_spec_err),
`endif
    .o_busy(o_busy), .o_wait(o_wait)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // storage model
  logic [31:0]       mem [0:63];
  int                lat = 1;
  bit                ack_noise = 1'b0;
  int                rq_cnt = 0;
  bit                prev_ack = 1'b0;
  int                stab_bad = 0;
  int                dead_bad = 0;
  logic [ADDR_W-1:0] s_addr;
  logic              s_we;
  logic [31:0]       s_wd;
  logic [ADDR_W-1:0] q_addr[$];
  logic              q_we[$];
  logic [31:0]       q_data[$];

  // Storage responder: acks in the lat-th cycle of each request, logs accesses
  always @(negedge i_clk) begin
    if (i_reset) begin
      i_mem_ack = 1'b0;
      rq_cnt    = 0;
      prev_ack  = 1'b0;
    end else if (o_mem_req) begin
      if (prev_ack) dead_bad++;
      if (rq_cnt == 0) begin
        s_addr = o_mem_addr; s_we = o_mem_we; s_wd = o_mem_wdata;
      end else if (o_mem_addr !== s_addr || o_mem_we !== s_we || (o_mem_we && o_mem_wdata !== s_wd)) begin
        stab_bad++;
      end
      rq_cnt++;
      if (rq_cnt >= lat) begin
        i_mem_ack = 1'b1;
        rq_cnt    = 0;
        prev_ack  = 1'b1;
        q_addr.push_back(o_mem_addr);
        q_we.push_back(o_mem_we);
        if (o_mem_we) begin
          q_data.push_back(o_mem_wdata);
          i_mem_rdata = $urandom;
        end else begin
          i_mem_rdata = mem[o_mem_addr[7:2]];
          q_data.push_back(i_mem_rdata);
        end
      end else begin
        i_mem_ack   = 1'b0;
        prev_ack    = 1'b0;
        i_mem_rdata = $urandom;
      end
    end else begin
      prev_ack    = 1'b0;
      rq_cnt      = 0;
      i_mem_ack   = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      i_mem_rdata = $urandom;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: class enables and priority straight from the rules
  function automatic logic [4:0] model_sel(input logic mck, pgm, svc, ext,
                                           input logic [5:0] io, input logic [7:0] sm,
                                           input logic [3:0] amwp, output int chan);
    chan = -1;
    for (int n = 0; n < 6; n++) if (chan < 0 && io[n] && sm[7-n]) chan = n;
    if (mck && amwp[2]) return 5'b10000;
    if (pgm)            return 5'b01000;
    if (svc)            return 5'b00100;
    if (ext && sm[0])   return 5'b00010;
    if (chan >= 0)      return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic int model_old(input logic [4:0] sel);
    case (sel)
      5'b10000: return 'h30;
      5'b01000: return 'h28;
      5'b00100: return 'h20;
      5'b00010: return 'h18;
      5'b00001: return 'h38;
      default:  return 0;
    endcase
  endfunction

  task automatic clear_reqs();
    i_mck_req = 0; i_pgm_req = 0; i_svc_req = 0; i_ext_req = 0; i_io_req = '0;
  endtask

  // Runs one swap from the current inputs; caller has raised i_ros_advance
  task automatic do_swap(input bit keep_adv, input bit scramble, output int n,
                         output logic [63:0] npsw, output logic [4:0] gnt, output logic serr);
    q_addr.delete(); q_we.delete(); q_data.delete();
    stab_bad = 0; dead_bad = 0;
    n = 0; npsw = '0; gnt = '0; serr = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (n == 1 && !keep_adv) i_ros_advance = 1'b0;
      if (scramble) begin
        i_mck_req = 1'($urandom); i_pgm_req = 1'($urandom); i_svc_req = 1'($urandom);
        i_ext_req = 1'($urandom); i_io_req = 6'($urandom); i_sysmask = 8'($urandom);
        i_psw = {$urandom, $urandom}; i_int_code = 16'($urandom); i_ilc = 2'($urandom);
      end
      if (o_psw_load) begin
        npsw = o_new_psw; gnt = o_grant;
`ifdef X2050_NEWPSW_CHECK_EN
        serr = o_spec_err;
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) tick();
    tests++; if ({o_busy, o_mem_req, o_psw_load, o_mem_we} !== 4'b0) begin fails++;
      $display("FAIL reset_ctl: got %b want 0000", {o_busy, o_mem_req, o_psw_load, o_mem_we}); end
    tests++; if (o_new_psw !== 64'h0 || o_grant !== 5'h0) begin fails++;
      $display("FAIL reset_psw: got %h/%b want 0/00000", o_new_psw, o_grant); end
    tests++; if (o_mem_addr !== '0 || o_sel !== 5'h0 || o_wait !== 1'b0) begin fails++;
      $display("FAIL reset_out: addr %h sel %b wait %b want 0", o_mem_addr, o_sel, o_wait); end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_ext_single();
    int n; logic [63:0] npsw, exp_psw; logic [4:0] gnt; logic serr;
    logic [ADDR_W-1:0] ea [4];
    ea = '{24'h18, 24'h1C, 24'h58, 24'h5C};
    lat = 1; ack_noise = 0;
    i_ext_req = 1; i_sysmask = 8'h01; i_amwp = 4'h0;
    exp_psw = {mem['h58 >> 2], mem['h5C >> 2]};
    tick();
    tests++; if (o_sel !== 5'b00010) begin fails++; $display("FAIL ext_sel: got %b want 00010", o_sel); end
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (n !== 9) begin fails++; $display("FAIL ext_cycles: got %0d want 9", n); end
    tests++; if (gnt !== 5'b00010) begin fails++; $display("FAIL ext_grant: got %b want 00010", gnt); end
    tests++; if (npsw !== exp_psw) begin fails++; $display("FAIL ext_newpsw: got %h want %h", npsw, exp_psw); end
    tests++; if (q_addr.size() !== 4) begin fails++; $display("FAIL ext_naccess: got %0d want 4", q_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests++; if (q_addr[i] !== ea[i] || q_we[i] !== (i < 2)) begin fails++;
        $display("FAIL ext_access%0d: got %h we %b want %h we %b", i, q_addr[i], q_we[i], ea[i], i < 2); end
    end
    tests++; if (dead_bad !== 0) begin fails++; $display("FAIL ext_deadcycle: got %0d want 0", dead_bad); end
    i_ext_req = 0;
    tick();
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL ext_idle: got %b want 0", o_busy); end
  endtask

  task automatic test_priority();
    int n; logic [63:0] npsw; logic [4:0] gnt; logic serr;
    i_mck_req = 1; i_ext_req = 1; i_io_req = 6'b000100; i_sysmask = 8'hFF; i_amwp = 4'b0100;
    tick();
    tests++; if (o_sel !== 5'b10000) begin fails++; $display("FAIL pri_sel_m1: got %b want 10000", o_sel); end
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (gnt !== 5'b10000) begin fails++; $display("FAIL pri_grant_m1: got %b want 10000", gnt); end
    tests++; if (q_addr.size() !== 4 || q_addr[0] !== 24'h30 || q_addr[2] !== 24'h70) begin fails++;
      $display("FAIL pri_addr_m1: got %0d accesses, first %h want 30/70", q_addr.size(), q_addr[0]); end
    i_amwp = 4'b0000;
    tick();
    tests++; if (o_sel !== 5'b00010) begin fails++; $display("FAIL pri_sel_m0: got %b want 00010", o_sel); end
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (gnt !== 5'b00010 || q_addr.size() !== 4 || q_addr[0] !== 24'h18) begin fails++;
      $display("FAIL pri_m0: got grant %b addr %h want 00010/18", gnt, q_addr[0]); end
    clear_reqs();
    tick();
  endtask

  task automatic test_code_ilc();
    int n; logic [63:0] npsw; logic [4:0] gnt; logic serr;
    i_pgm_req = 1; i_psw = 64'hFF0E_0000_8000_1234; i_int_code = 16'h0042; i_ilc = 2'd2;
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (q_data.size() !== 4 || q_data[0] !== 32'hFF0E_0042 || q_data[1] !== 32'h8000_1234) begin fails++;
      $display("FAIL code_words: got %h %h want ff0e0042 80001234", q_data[0], q_data[1]); end
    tests++; if (gnt !== 5'b01000 || q_addr[0] !== 24'h28) begin fails++;
      $display("FAIL code_grant: got %b addr %h want 01000/28", gnt, q_addr[0]); end
    tick();
    i_ilc = 2'd1; i_int_code = 16'hBEEF;
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (q_data.size() !== 4 || q_data[0] !== 32'hFF0E_BEEF || q_data[1] !== 32'h4000_1234) begin fails++;
      $display("FAIL ilc_words: got %h %h want ff0ebeef 40001234", q_data[0], q_data[1]); end
    clear_reqs(); i_psw = '0; i_int_code = '0; i_ilc = '0;
    tick();
  endtask

  task automatic test_ack_delay();
    int n; logic [63:0] npsw; logic [4:0] gnt; logic serr;
    lat = 3; ack_noise = 1;
    i_svc_req = 1;
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (n !== 17) begin fails++; $display("FAIL delay_cycles: got %0d want 17", n); end
    tests++; if (stab_bad !== 0 || dead_bad !== 0) begin fails++;
      $display("FAIL delay_handshake: got stab %0d dead %0d want 0 0", stab_bad, dead_bad); end
    tests++; if (q_addr.size() !== 4 || gnt !== 5'b00100) begin fails++;
      $display("FAIL delay_result: got %0d accesses grant %b want 4/00100", q_addr.size(), gnt); end
    lat = 1; ack_noise = 0;
    clear_reqs();
    tick();
  endtask

  task automatic test_reset_mid_swap();
    int loads = 0;
    i_sysmask = 8'h04; i_io_req = 6'b101000;
    tick();
    tests++; if (o_sel !== 5'b00001 || o_io_chan !== 3'd5) begin fails++;
      $display("FAIL io_sel: got %b chan %0d want 00001 chan 5", o_sel, o_io_chan); end
    q_addr.delete(); q_we.delete(); q_data.delete();
    i_ros_advance = 1;
    repeat (5) tick();
    i_ros_advance = 0;
    tests++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 24'h78) begin fails++;
      $display("FAIL io_ld0: got req %b we %b addr %h want 1 0 78", o_mem_req, o_mem_we, o_mem_addr); end
    tests++; if (q_addr.size() < 1 || q_addr[0] !== 24'h38) begin fails++;
      $display("FAIL io_oldslot: got %h want 38", q_addr[0]); end
    i_reset = 1;
    tick();
    tests++; if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_new_psw !== 64'h0) begin fails++;
      $display("FAIL midreset: got req %b busy %b psw %h want 0 0 0", o_mem_req, o_busy, o_new_psw); end
    i_reset = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_psw_load) loads++;
      tick();
    end
    tests++; if (loads !== 0) begin fails++; $display("FAIL midreset_load: got %0d want 0", loads); end
    clear_reqs(); i_sysmask = '0;
    tick();
  endtask

  task automatic test_wait();
    int n; logic [63:0] npsw; logic [4:0] gnt; logic serr;
    i_amwp = 4'b0010;
    tick();
    tests++; if (o_wait !== 1'b1) begin fails++; $display("FAIL wait_on: got %b want 1", o_wait); end
    i_ext_req = 1; i_sysmask = 8'h00;
    tick();
    tests++; if (o_wait !== 1'b1) begin fails++; $display("FAIL wait_masked: got %b want 1", o_wait); end
    i_pgm_req = 1;
    tick();
    tests++; if (o_wait !== 1'b0) begin fails++; $display("FAIL wait_off: got %b want 0", o_wait); end
    i_ext_req = 0;
    mem['h6C >> 2] = 32'h0000_0101;
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (npsw[31:0] !== 32'h0000_0101) begin fails++; $display("FAIL wait_newpsw: got %h want 00000101", npsw[31:0]); end
`ifdef X2050_NEWPSW_CHECK_EN
    tests++; if (serr !== 1'b1) begin fails++; $display("FAIL spec_err_odd: got %b want 1", serr); end
    mem['h6C >> 2] = 32'h0000_0100;
    tick();
    i_ros_advance = 1;
    do_swap(0, 0, n, npsw, gnt, serr);
    tests++; if (serr !== 1'b0) begin fails++; $display("FAIL spec_err_even: got %b want 0", serr); end
`endif
    clear_reqs(); i_amwp = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n; logic [63:0] npsw; logic [4:0] gnt; logic serr;
    i_svc_req = 1; i_ext_req = 1; i_sysmask = 8'h01;
    i_ros_advance = 1;
    do_swap(1, 0, n, npsw, gnt, serr);
    tests++; if (gnt !== 5'b00100 || n !== 9) begin fails++; $display("FAIL b2b_first: got %b n %0d want 00100 n 9", gnt, n); end
    i_svc_req = 0;
    do_swap(1, 0, n, npsw, gnt, serr);
    tests++; if (gnt !== 5'b00010 || n !== 10) begin fails++; $display("FAIL b2b_second: got %b n %0d want 00010 n 10", gnt, n); end
    i_ros_advance = 0; i_ext_req = 0; i_sysmask = '0;
    tick();
  endtask

  task automatic test_random();
    int n, chan, old, l;
    logic [63:0] npsw, exp_psw, psw;
    logic [4:0] gnt, esel;
    logic serr;
    logic [15:0] code;
    logic [1:0] ilc;
    logic [31:0] ew [4];
    for (int it = 0; it < 30; it++) begin
      i_mck_req = ($urandom_range(0, 3) == 0); i_pgm_req = ($urandom_range(0, 5) == 0);
      i_svc_req = ($urandom_range(0, 5) == 0); i_ext_req = ($urandom_range(0, 2) == 0);
      i_io_req = 6'($urandom); i_sysmask = 8'($urandom); i_amwp = 4'($urandom);
      psw = {$urandom, $urandom}; code = 16'($urandom); ilc = 2'($urandom);
      i_psw = psw; i_int_code = code; i_ilc = ilc;
      l = $urandom_range(1, 4); lat = l; ack_noise = 1'($urandom);
      esel = model_sel(i_mck_req, i_pgm_req, i_svc_req, i_ext_req, i_io_req, i_sysmask, i_amwp, chan);
      tick();
      tests++; if (o_sel !== esel) begin fails++; $display("FAIL rnd_sel[%0d]: got %b want %b", it, o_sel, esel); end
      if (esel == 5'b0) begin
        tests++; if (o_wait !== i_amwp[1]) begin fails++; $display("FAIL rnd_wait[%0d]: got %b want %b", it, o_wait, i_amwp[1]); end
        i_ros_advance = 1;
        repeat (3) tick();
        i_ros_advance = 0;
        tests++; if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin fails++;
          $display("FAIL rnd_nostart[%0d]: got busy %b req %b want 0 0", it, o_busy, o_mem_req); end
      end else begin
        if (esel == 5'b00001) begin
          tests++; if (o_io_chan !== 3'(chan)) begin fails++; $display("FAIL rnd_chan[%0d]: got %0d want %0d", it, o_io_chan, chan); end
        end
        old = model_old(esel);
        for (int k = 0; k < 2; k++) mem[((old + 'h40) >> 2) + k] = $urandom;
        exp_psw = {mem[(old + 'h40) >> 2], mem[((old + 'h40) >> 2) + 1]};
        ew[0] = {psw[63:48], code};
        ew[1] = {ilc, psw[29:0]};
        ew[2] = exp_psw[63:32];
        ew[3] = exp_psw[31:0];
        i_ros_advance = 1;
        do_swap(0, 1, n, npsw, gnt, serr);
        tests++; if (n !== 4 * (l + 1) + 1) begin fails++; $display("FAIL rnd_cycles[%0d]: got %0d want %0d", it, n, 4 * (l + 1) + 1); end
        tests++; if (gnt !== esel) begin fails++; $display("FAIL rnd_grant[%0d]: got %b want %b", it, gnt, esel); end
        tests++; if (npsw !== exp_psw) begin fails++; $display("FAIL rnd_newpsw[%0d]: got %h want %h", it, npsw, exp_psw); end
        tests++; if (stab_bad !== 0 || dead_bad !== 0) begin fails++;
          $display("FAIL rnd_handshake[%0d]: got stab %0d dead %0d want 0 0", it, stab_bad, dead_bad); end
`ifdef X2050_NEWPSW_CHECK_EN
        tests++; if (serr !== exp_psw[0]) begin fails++; $display("FAIL rnd_specerr[%0d]: got %b want %b", it, serr, exp_psw[0]); end
`endif
        tests++; if (q_addr.size() !== 4) begin fails++; $display("FAIL rnd_naccess[%0d]: got %0d want 4", it, q_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
          tests++;
          if (q_addr[i] !== ADDR_W'(old + (i >= 2 ? 'h40 : 0) + 4 * (i % 2)) || q_we[i] !== (i < 2) || q_data[i] !== ew[i]) begin
            fails++;
            $display("FAIL rnd_access[%0d.%0d]: got %h/%b/%h want %h/%b/%h", it, i, q_addr[i], q_we[i], q_data[i],
                     ADDR_W'(old + (i >= 2 ? 'h40 : 0) + 4 * (i % 2)), i < 2, ew[i]);
          end
        end
      end
      clear_reqs();
      tick();
    end
    lat = 1; ack_noise = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_ext_single();
    test_priority();
    test_code_ilc();
    test_ack_delay();
    test_reset_mid_swap();
    test_wait();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
